tft_frame_reader: RTL
=====================

Name: tft_frame_reader

Overview:
Prefetch stage directly upstream of the TFT timing controller. It fetches one frame of RGB565 pixels from frame memory in bursts, buffers them in a show-ahead FIFO, and presents a pixel on data_out whenever the controller raises data_req.
- It restarts at the frame base address on every frame_start.
- All logic runs on the pixel clock.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 480, active lines per frame
BASE_ADDR, 0, word address of pixel (0,0)
AW, 24, memory word-address width
BURST, 64, maximum words per read request (≤ FIFO_DEPTH/2)
FIFO_DEPTH, 512, buffer depth in 16-bit words (power of two)

Ports:
clk33m  in  1  pixel clock; the only clock
rst_n  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle pulse, issued during vertical blanking before the first active line
data_req  in  1  controller consumes the current data_out pixel this cycle
data_out  out  16  RGB565 pixel at the FIFO head (show-ahead)
rd_req  out  1  burst read request to the memory arbiter
rd_addr  out  AW  burst start word address
rd_len  out  9  burst length in words, 1..BURST
rd_ack  in  1  arbiter accepted the request
rd_valid  in  1  one read word on rd_data
rd_data  in  16  read word
fifo_level  out  log2(FIFO_DEPTH)+1  current buffer occupancy
underflow  out  1  sticky: data_req seen while the FIFO was empty

Behaviour:
- Reset values: data_out=0, rd_req=0, rd_addr=BASE_ADDR, rd_len=0, fifo_level=0, underflow=0, state=IDLE, FIFO empty.
- Data path:
  - data_out is combinational from the FIFO head, so it is valid in the same cycle as data_req.
  - data_out=16'h0000 when the FIFO is empty.
  - A pop occurs on data_req && !empty.
  - data_req && empty sets underflow. underflow clears only on frame_start or reset.
- Push occurs on rd_valid, except in FLUSH. Simultaneous push and pop leave fifo_level unchanged.
- fifo_level counts committed words. Space available for a request is FIFO_DEPTH − fifo_level − outstanding, where outstanding = words requested but not yet received.
- Frame counters:
  - words_left starts at H_ACTIVE*V_ACTIVE; next_addr starts at BASE_ADDR.
  - On rd_ack: next_addr += rd_len, words_left −= rd_len.
- FSM:
  - IDLE: wait for frame_start, then go to LOAD.
  - LOAD: one cycle. Reset the frame counters, clear underflow, then go to CHECK.
  - CHECK:
    - If words_left==0, stay in CHECK until frame_start.
    - Else, if space ≥ min(BURST, words_left), drive rd_req=1 with rd_addr=next_addr and rd_len=min(BURST, words_left), then go to REQ.
  - REQ: hold rd_req, rd_addr and rd_len stable until rd_ack. rd_req drops in the cycle after ack. Go to RECV.
  - RECV: count rd_valid words. After rd_len words, go to CHECK.
- Only one burst is outstanding at a time.
- frame_start in CHECK, or when idle in the frame:
  - Flush the FIFO (level to 0) and go to LOAD.
- frame_start in REQ or RECV:
  - Latch the restart.
  - In REQ: if it arrives before rd_ack, drop rd_req and go to LOAD. Abandoning a request is legal only before ack.
  - In RECV: go to FLUSH and discard the remaining words of the current burst. Then flush the FIFO and go to LOAD.
- Reset asserted mid-burst returns everything to reset values at once. Any words still arriving are ignored in IDLE.
- Widths: words_left is sized to hold H_ACTIVE*V_ACTIVE. next_addr wraps modulo 2^AW.

Decomposition:
- Shared package tft_pkg holds:
  - The H_ACTIVE and V_ACTIVE defaults, so they are shared with the timing controller.
  - The RGB565 pixel type.
  - The reader FSM state encoding.
- One natural sub-module: tft_sync_fifo. It is a single-clock, show-ahead FIFO with push, pop, flush, a level output and a DEPTH parameter, and is reusable elsewhere.

Test Plan:
1. Reset, then frame_start with an ideal arbiter (ack next cycle, data 1 word/cycle, data = address) → first request addr=0, len=64. Requests continue until the FIFO holds ≥448 words plus outstanding; no requests beyond 512 total space.
2. Full frame with data_req pattern 800 on / 256 off ×480 → data_out sequence is 0..383999 in order. 6000 requests total, each len 64. underflow stays 0.
3. H_ACTIVE=10, V_ACTIVE=10, BURST=64 → single request len=64, then a final request len=36. words_left reaches 0 and no further rd_req occurs.
4. data_req asserted with the FIFO empty → data_out=0, underflow=1. It stays 1 until the next frame_start, then clears.
5. frame_start after 20 of 64 burst words have arrived → remaining 44 words are discarded and the FIFO is empty. The next request is addr=BASE_ADDR, and the first popped pixel equals word 0.
6. rst_n pulsed low mid-RECV → all outputs return to reset values asynchronously. No rd_req occurs until the next frame_start.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared TFT definitions: panel geometry defaults, the RGB565 pixel type and
// the frame-reader FSM state encoding.
package tft_pkg;

  localparam int unsigned TFT_H_ACTIVE = 800;
  localparam int unsigned TFT_V_ACTIVE = 480;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_LOAD,
    RD_CHECK,
    RD_REQ,
    RD_RECV,
    RD_FLUSH
  } rd_state_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tft_sync_fifo.sv
// Single-clock show-ahead FIFO of RGB565 words with flush and occupancy output.
// The head word is visible combinationally; an empty FIFO presents zero.
module tft_sync_fifo
  import tft_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  rgb565_t       din_i,
  input  logic          pop_i,
  output rgb565_t       dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o
);

  rgb565_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  // Flush wins over any same-cycle push or pop.
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/tft_frame_reader.sv
// Frame prefetcher for the TFT timing controller: bursts one frame of RGB565
// words from memory into a show-ahead FIFO, restarting on every frame_start.
module tft_frame_reader
  import tft_pkg::*;
#(
  parameter  int unsigned   H_ACTIVE   = TFT_H_ACTIVE,
  parameter  int unsigned   V_ACTIVE   = TFT_V_ACTIVE,
  parameter  int unsigned   AW         = 24,
  parameter  logic [AW-1:0] BASE_ADDR  = '0,
  parameter  int unsigned   BURST      = 64,
  parameter  int unsigned   FIFO_DEPTH = 512,
  localparam int            LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk33m,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          data_req,
  output logic [15:0]   data_out,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  output logic [8:0]    rd_len,
  input  logic          rd_ack,
  input  logic          rd_valid,
  input  logic [15:0]   rd_data,
  output logic [LW-1:0] fifo_level,
  output logic          underflow
);

  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;
  localparam int          WLW  = $clog2(NPIX + 1);

  rd_state_e      state_q;
  logic [WLW-1:0] words_left_q;
  logic [AW-1:0]  next_addr_q, rd_addr_q;
  logic [8:0]     rd_len_q, rcv_left_q;
  logic           rd_req_q, underflow_q, underflow_d;

  rgb565_t        head;
  logic           fifo_empty, fifo_full, fifo_push, fifo_flush;
  logic [8:0]     want;
  logic           room;

  // rcv_left_q doubles as the outstanding-word count of the single live burst.
  assign want = 9'(min_u32(32'(BURST), 32'(words_left_q)));
  assign room = (32'(fifo_level) + 32'(rcv_left_q) + 32'(want)) <= 32'(FIFO_DEPTH);

  // A restart empties the buffer at once; FLUSH keeps it empty while the
  // tail of an abandoned burst drains.
  assign fifo_flush = frame_start || (state_q == RD_FLUSH);
  assign fifo_push  = rd_valid && !fifo_full &&
                      (state_q != RD_IDLE) && (state_q != RD_FLUSH);

  tft_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk33m),
    .rst_n_i (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (rd_data),
    .pop_i   (data_req),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign data_out  = head;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign underflow = underflow_q;

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      words_left_q <= WLW'(NPIX);
      next_addr_q  <= BASE_ADDR;
      rd_addr_q    <= BASE_ADDR;
      rd_len_q     <= '0;
      rd_req_q     <= 1'b0;
      rcv_left_q   <= '0;
    end else begin
      unique case (state_q)
        RD_IDLE: if (frame_start) state_q <= RD_LOAD;
        RD_LOAD: begin
          words_left_q <= WLW'(NPIX);
          next_addr_q  <= BASE_ADDR;
          state_q      <= frame_start ? RD_LOAD : RD_CHECK;
        end
        RD_CHECK: begin
          if (frame_start) begin
            state_q <= RD_LOAD;
          end else if (words_left_q != '0 && room) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= next_addr_q;
            rd_len_q  <= want;
            state_q   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (rd_ack) begin
            // Once accepted the burst is owed to us; a same-cycle restart drains it.
            rd_req_q     <= 1'b0;
            next_addr_q  <= next_addr_q + AW'(rd_len_q);
            words_left_q <= words_left_q - WLW'(rd_len_q);
            rcv_left_q   <= rd_len_q;
            state_q      <= frame_start ? RD_FLUSH : RD_RECV;
          end else if (frame_start) begin
            rd_req_q <= 1'b0;
            state_q  <= RD_LOAD;
          end
        end
        RD_RECV: begin
          rcv_left_q <= rcv_left_q - 9'(rd_valid);
          if (frame_start)                          state_q <= RD_FLUSH;
          else if (rd_valid && rcv_left_q == 9'd1)  state_q <= RD_CHECK;
        end
        RD_FLUSH: begin
          if (rcv_left_q == '0) state_q    <= RD_LOAD;
          else                  rcv_left_q <= rcv_left_q - 9'(rd_valid);
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    underflow_d = underflow_q;
    if (state_q == RD_LOAD)       underflow_d = 1'b0;
    if (data_req && fifo_empty)   underflow_d = 1'b1;
    if (frame_start)              underflow_d = 1'b0;
  end

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

endmodule
